// File: rtl/lanczos_phase_ctrl.sv
// Lanczos coefficient ROM sequencer: steps a fixed-point source position per output
// pixel, drives the ROM address and emits a descriptor aligned with the ROM output.
module lanczos_phase_ctrl #(
  parameter int PIXEL_STEP = 4096,
  parameter int LINE_W     = 16,
  parameter int STEP_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [STEP_W-1:0]                    i_cfg_step,
  input  logic [$clog2(PIXEL_STEP)-1:0]        i_cfg_phase0,
  input  logic [LINE_W-1:0]                    i_cfg_in_width,
  input  logic [LINE_W-1:0]                    i_cfg_out_width,
  input  logic [LINE_W-1:0]                    i_cfg_out_height,
  input  logic [LINE_W-1:0]                    i_src_cnt,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_line_done,
  output logic [$clog2(PIXEL_STEP/4)-1:0]      o_tbl_dx,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [LINE_W-1:0]                    o_out_src_x,
  output logic                                 o_out_eol,
  output logic                                 o_out_eof
);

  localparam int FRAC_W = $clog2(PIXEL_STEP);
  localparam int DX_W   = $clog2(PIXEL_STEP / 4);
  localparam int POS_W  = LINE_W + FRAC_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LINE_INIT = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic [1:0]        r_state;
  logic [STEP_W-1:0] r_step;
  logic [FRAC_W-1:0] r_phase0;
  logic [LINE_W-1:0] r_in_w;
  logic [LINE_W-1:0] r_out_w;
  logic [LINE_W-1:0] r_out_h;
  logic [POS_W-1:0]  r_pos;
  logic [LINE_W-1:0] r_pix_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_line_done;
  logic              r_out_valid;
  logic [LINE_W-1:0] r_out_src_x;
  logic [DX_W-1:0]   r_out_dx;
  logic              r_out_eol;
  logic              r_out_eof;

  logic [LINE_W-1:0] w_cand_x;
  logic [DX_W-1:0]   w_cand_dx;
  logic [LINE_W:0]   w_x_plus3;
  logic [LINE_W:0]   w_in_last;
  logic [LINE_W:0]   w_need;
  logic              w_cand_ok;
  logic              w_load;
  logic              w_fire;
  logic              w_eol_next;
  logic              w_last_line;

  assign w_cand_x  = r_pos[POS_W-1:FRAC_W];
  assign w_cand_dx = r_pos[FRAC_W-1:2];

  // Rightmost tap is clamped to the line end, so a short line never waits for pixels it lacks.
  assign w_x_plus3   = {1'b0, w_cand_x} + {{(LINE_W-1){1'b0}}, 2'd3};
  assign w_in_last   = {1'b0, r_in_w} - {{LINE_W{1'b0}}, 1'b1};
  assign w_need      = (w_x_plus3 < w_in_last) ? w_x_plus3 : w_in_last;
  assign w_cand_ok   = (w_need < {1'b0, i_src_cnt});
  assign w_fire      = r_out_valid & i_out_ready;
  assign w_load      = (r_state == S_RUN) & w_cand_ok & (~r_out_valid | i_out_ready);
  assign w_eol_next  = (r_pix_cnt == (r_out_w - {{(LINE_W-1){1'b0}}, 1'b1}));
  assign w_last_line = (r_line_cnt == (r_out_h - {{(LINE_W-1){1'b0}}, 1'b1}));

  // ROM address leads the descriptor by one cycle so registered coefficients line up with out_*.
  assign o_tbl_dx = w_load ? w_cand_dx : r_out_dx;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_line_done = r_line_done;
  assign o_out_valid = r_out_valid;
  assign o_out_src_x = r_out_src_x;
  assign o_out_eol   = r_out_eol;
  assign o_out_eof   = r_out_eof;

  // Frame sequencer, position accumulator and descriptor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= {STEP_W{1'b0}};
      r_phase0    <= {FRAC_W{1'b0}};
      r_in_w      <= {LINE_W{1'b0}};
      r_out_w     <= {LINE_W{1'b0}};
      r_out_h     <= {LINE_W{1'b0}};
      r_pos       <= {POS_W{1'b0}};
      r_pix_cnt   <= {LINE_W{1'b0}};
      r_line_cnt  <= {LINE_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_line_done <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_src_x <= {LINE_W{1'b0}};
      r_out_dx    <= {DX_W{1'b0}};
      r_out_eol   <= 1'b0;
      r_out_eof   <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_line_done <= 1'b0;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_src_x <= w_cand_x;
        r_out_dx    <= w_cand_dx;
        r_out_eol   <= w_eol_next;
        r_out_eof   <= w_eol_next & w_last_line;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
      case (r_state)
        S_IDLE: begin
          // busy is still high during the done cycle, which also blocks a start there.
          r_busy <= 1'b0;
          if (i_start && !r_busy) begin
            r_step     <= i_cfg_step;
            r_phase0   <= i_cfg_phase0;
            r_in_w     <= i_cfg_in_width;
            r_out_w    <= i_cfg_out_width;
            r_out_h    <= i_cfg_out_height;
            r_line_cnt <= {LINE_W{1'b0}};
            r_busy     <= 1'b1;
            r_state    <= S_LINE_INIT;
          end
        end
        S_LINE_INIT: begin
          r_pos     <= {{LINE_W{1'b0}}, r_phase0};
          r_pix_cnt <= {LINE_W{1'b0}};
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (w_load) begin
            r_pos     <= r_pos + {{(POS_W-STEP_W){1'b0}}, r_step};
            r_pix_cnt <= r_pix_cnt + {{(LINE_W-1){1'b0}}, 1'b1};
            if (w_eol_next) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_fire && r_out_eol) begin
            r_line_done <= 1'b1;
            if (r_out_eof) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_line_cnt <= r_line_cnt + {{(LINE_W-1){1'b0}}, 1'b1};
              r_state    <= S_LINE_INIT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
